laser_host: RTL and testbench

- Host/stimulus side of the LASER solver interface.
- Holds a 40-entry point set written over a simple write port and resets the solver.
- Streams one point per cycle on X/Y and waits for DONE, then captures C1/C2.
- While streaming the next pass, scores the captured centres by counting points within radius 4 of either centre, and reports the count plus pass/fail against an expected value. Repeats for a programmed number of frames.

---
 rtl/laser_host.sv | 207 ++++++++++++++++++++
 tb/tb_laser_host.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_host.sv
// laser_host: host/stimulus side of the LASER solver interface.
// Define LASER_HOST_CONSIST_EN to add the INCONSIST centre-consistency check.
module laser_host #(
  parameter int unsigned NPTS        = 40,
  parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WR_EN,
  input  logic [5:0] WR_ADDR,
  input  logic [3:0] WR_X,
  input  logic [3:0] WR_Y,
  input  logic       START,
  input  logic [3:0] FRAMES,
  input  logic [5:0] EXP_CNT,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic       LASER_RST,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       BUSY,
  output logic       RES_VALID,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic [5:0] COVER_CNT,
  output logic       FAIL,
`ifdef LASER_HOST_CONSIST_EN
  output logic       TIMEOUT,
  output logic       INCONSIST
`else
  output logic       TIMEOUT
`endif
);

  localparam int unsigned IDX_W = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);
  localparam logic [8:0] RAD_SQ = 9'd16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RSTQ   = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               score_en_q;
  logic [5:0]         acc_q;
  logic [3:0]         frames_q;
  logic [3:0]         frames_done_q;
  logic [5:0]         exp_q;
  logic [15:0]        tcnt_q;
  logic [3:0]         pt_x [NPTS];
  logic [3:0]         pt_y [NPTS];

  logic               last_c, tmo_c, hit_c;
  logic [5:0]         acc_sum_c;
  logic [IDX_W-1:0]   rd_idx_c;
  logic               laser_rst_d, busy_d, res_valid_d;
  logic               start_acc_c, wr_acc_c, capture_c, tmo_set_c, stream_entry_c;

  // Squared Euclidean distance; max 15^2+15^2 = 450 fits 9 bits.
  function automatic logic [8:0] dist2(input logic [3:0] ax, input logic [3:0] ay,
                                       input logic [3:0] bx, input logic [3:0] by);
    logic [7:0] dx, dy;
    dx = {4'd0, (ax >= bx) ? ax - bx : bx - ax};
    dy = {4'd0, (ay >= by) ? ay - by : by - ay};
    return {1'b0, dx * dx} + {1'b0, dy * dy};
  endfunction

  assign last_c    = (idx_q == LAST_IDX);
  assign tmo_c     = (tcnt_q == TIMEOUT_CYC - 16'd1);
  assign hit_c     = score_en_q &&
                     ((dist2(X, Y, RES_C1X, RES_C1Y) <= RAD_SQ) ||
                      (dist2(X, Y, RES_C2X, RES_C2Y) <= RAD_SQ));
  assign acc_sum_c = acc_q + {5'd0, hit_c};
  assign rd_idx_c  = (state_q == S_STREAM && !last_c) ? idx_q + IDX_W'(1) : '0;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (START) state_d = S_RSTQ;
      S_RSTQ:   state_d = S_STREAM;
      S_STREAM: if (last_c) state_d = score_en_q ? S_REPORT : S_WAIT;
      S_WAIT: begin
        if (DONE)       state_d = S_STREAM;
        else if (tmo_c) state_d = S_IDLE;
      end
      S_REPORT: state_d = (frames_done_q < frames_q) ? S_WAIT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath decode; every registered output is loaded from these
  always_comb begin
    laser_rst_d    = (state_d == S_RSTQ);
    busy_d         = (state_d != S_IDLE);
    res_valid_d    = (state_d == S_REPORT);
    start_acc_c    = (state_q == S_IDLE) && START;
    wr_acc_c       = (state_q == S_IDLE) && WR_EN && (WR_ADDR <= LAST_IDX);
    capture_c      = (state_q == S_WAIT) && DONE;
    tmo_set_c      = (state_q == S_WAIT) && !DONE && tmo_c;
    stream_entry_c = (state_d == S_STREAM) && (state_q != S_STREAM);
  end

  // Point RAM: intentionally not reset
  always_ff @(posedge CLK) begin
    if (wr_acc_c) begin
      pt_x[WR_ADDR] <= WR_X;
      pt_y[WR_ADDR] <= WR_Y;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LASER_RST     <= 1'b0;
      X             <= '0;
      Y             <= '0;
      BUSY          <= 1'b0;
      RES_VALID     <= 1'b0;
      RES_C1X       <= '0;
      RES_C1Y       <= '0;
      RES_C2X       <= '0;
      RES_C2Y       <= '0;
      COVER_CNT     <= '0;
      FAIL          <= 1'b0;
      TIMEOUT       <= 1'b0;
`ifdef LASER_HOST_CONSIST_EN
      INCONSIST     <= 1'b0;
`endif
      idx_q         <= '0;
      score_en_q    <= 1'b0;
      acc_q         <= '0;
      frames_q      <= '0;
      frames_done_q <= '0;
      exp_q         <= '0;
      tcnt_q        <= '0;
    end else begin
      LASER_RST <= laser_rst_d;
      BUSY      <= busy_d;
      RES_VALID <= res_valid_d;
      tcnt_q    <= (state_q == S_WAIT) ? tcnt_q + 16'd1 : 16'd0;

      if (start_acc_c) begin
        frames_q      <= (FRAMES == 4'd0) ? 4'd1 : FRAMES;
        exp_q         <= EXP_CNT;
        TIMEOUT       <= 1'b0;
        frames_done_q <= '0;
`ifdef LASER_HOST_CONSIST_EN
        INCONSIST     <= 1'b0;
`endif
      end

      if (state_q == S_RSTQ) score_en_q <= 1'b0;

      if (state_d == S_STREAM) begin
        X <= pt_x[rd_idx_c];
        Y <= pt_y[rd_idx_c];
      end

      if (stream_entry_c) begin
        idx_q <= '0;
        acc_q <= '0;
      end else if (state_q == S_STREAM && !last_c) begin
        idx_q <= idx_q + IDX_W'(1);
        acc_q <= acc_sum_c;
      end

      // Last stream cycle of a scored pass: include its hit in the report
      if (state_q == S_STREAM && last_c && score_en_q) begin
        COVER_CNT <= acc_sum_c;
        FAIL      <= (acc_sum_c < exp_q);
      end

      if (capture_c) begin
        RES_C1X       <= C1X;
        RES_C1Y       <= C1Y;
        RES_C2X       <= C2X;
        RES_C2Y       <= C2Y;
        frames_done_q <= frames_done_q + 4'd1;
        score_en_q    <= 1'b1;
`ifdef LASER_HOST_CONSIST_EN
        if (frames_done_q != 4'd0 &&
            {C1X, C1Y, C2X, C2Y} != {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y})
          INCONSIST <= 1'b1;
`endif
      end

      if (tmo_set_c) TIMEOUT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// tb_laser_host: randomized self-checking bench for laser_host against a
// point-set / coverage reference model.
module tb_laser_host;

  localparam int NP = 40;
  localparam int TO = 600;

  logic       CLK, RST_N, WR_EN, START, DONE;
  logic [5:0] WR_ADDR, EXP_CNT;
  logic [3:0] WR_X, WR_Y, FRAMES, C1X, C1Y, C2X, C2Y;
  logic       LASER_RST, BUSY, RES_VALID, FAIL, TIMEOUT;
  logic [3:0] X, Y, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
  logic [5:0] COVER_CNT;
`ifdef LASER_HOST_CONSIST_EN
  logic       INCONSIST;
`endif

  laser_host #(.NPTS(NP), .TIMEOUT_CYC(16'(TO))) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_X(WR_X), .WR_Y(WR_Y), .START(START), .FRAMES(FRAMES),
    .EXP_CNT(EXP_CNT), .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X),
    .C2Y(C2Y), .LASER_RST(LASER_RST), .X(X), .Y(Y), .BUSY(BUSY),
    .RES_VALID(RES_VALID), .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y),
    .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y), .COVER_CNT(COVER_CNT),
    .FAIL(FAIL),
`ifdef LASER_HOST_CONSIST_EN
    .TIMEOUT(TIMEOUT), .INCONSIST(INCONSIST)
`else
    .TIMEOUT(TIMEOUT)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rv_cnt = 0;
  logic [3:0] px [NP];
  logic [3:0] py [NP];
  int cc1x [16], cc1y [16], cc2x [16], cc2y [16];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count result pulses independently of the sequenced checks
  always @(posedge CLK) if (RES_VALID === 1'b1) rv_cnt <= rv_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic bit near(int ax, int ay, int bx, int by);
    return ((ax - bx) * (ax - bx) + (ay - by) * (ay - by)) <= 16;
  endfunction

  function automatic int model_cover(int f);
    int n = 0;
    for (int i = 0; i < NP; i++)
      if (near(px[i], py[i], cc1x[f], cc1y[f]) || near(px[i], py[i], cc2x[f], cc2y[f])) n++;
    return n;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_lrst"}, LASER_RST, 0);
    check({tag, "_xy"}, {X, Y}, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_rv"}, RES_VALID, 0);
    check({tag, "_cov"}, COVER_CNT, 0);
    check({tag, "_fail"}, FAIL, 0);
    check({tag, "_tmo"}, TIMEOUT, 0);
    check({tag, "_res"}, {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}, 0);
`ifdef LASER_HOST_CONSIST_EN
    check({tag, "_incon"}, INCONSIST, 0);
`endif
  endtask

  task automatic write_pt(input int a, input int x, input int y);
    WR_EN = 1'b1; WR_ADDR = 6'(a); WR_X = 4'(x); WR_Y = 4'(y);
    @(negedge CLK);
    WR_EN = 1'b0;
    if (a < NP) begin px[a] = 4'(x); py[a] = 4'(y); end
  endtask

  // One full stream pass; optionally pulses inputs that must be ignored while busy
  task automatic stream_check(input string tag, input bit inject);
    for (int k = 0; k < NP; k++) begin
      check({tag, "_xy"}, {X, Y}, {px[k], py[k]});
      if (k == 0) check({tag, "_lrst"}, LASER_RST, 0);
      if (inject && k == 12) begin
        WR_EN = 1'b1; WR_ADDR = 6'd0; WR_X = ~px[0]; WR_Y = ~py[0];
        START = 1'b1; DONE = 1'b1;
      end
      @(negedge CLK);
      WR_EN = 1'b0; START = 1'b0; DONE = 1'b0;
    end
  endtask

  task automatic run_frames(input string tag, input int fr, input int ex, input int dly,
                            input bit hang, input bit inject,
                            input bit wr_with_start, input int wa, input int wx, input int wy);
    int nf;
    int rv0;
    int cov;
    bit incon;
    nf = (fr == 0) ? 1 : fr;
    rv0 = rv_cnt;
    incon = 1'b0;
    START = 1'b1; FRAMES = 4'(fr); EXP_CNT = 6'(ex);
    if (wr_with_start) begin
      WR_EN = 1'b1; WR_ADDR = 6'(wa); WR_X = 4'(wx); WR_Y = 4'(wy);
      if (wa < NP) begin px[wa] = 4'(wx); py[wa] = 4'(wy); end
    end
    @(negedge CLK);
    START = 1'b0; WR_EN = 1'b0;
    FRAMES = 4'($urandom); EXP_CNT = 6'($urandom);
    check({tag, "_rstq_lrst"}, LASER_RST, 1);
    check({tag, "_rstq_busy"}, BUSY, 1);
    check({tag, "_rstq_tmo"}, TIMEOUT, 0);
`ifdef LASER_HOST_CONSIST_EN
    check({tag, "_rstq_incon"}, INCONSIST, 0);
`endif
    @(negedge CLK);
    stream_check({tag, "_s0"}, inject);
    for (int f = 0; f < nf; f++) begin
      if (hang) begin
        repeat (TO - 1) @(negedge CLK);
        check({tag, "_pre_tmo"}, TIMEOUT, 0);
        check({tag, "_pre_busy"}, BUSY, 1);
        @(negedge CLK);
        check({tag, "_tmo"}, TIMEOUT, 1);
        check({tag, "_tmo_busy"}, BUSY, 0);
        check({tag, "_tmo_rvcnt"}, 32'(rv_cnt - rv0), 0);
        return;
      end
      repeat (dly) @(negedge CLK);
      DONE = 1'b1;
      C1X = 4'(cc1x[f]); C1Y = 4'(cc1y[f]); C2X = 4'(cc2x[f]); C2Y = 4'(cc2y[f]);
      @(negedge CLK);
      DONE = 1'b0;
      {C1X, C1Y, C2X, C2Y} = 16'($urandom);
      stream_check({tag, "_s"}, inject);
      cov = model_cover(f);
      if (f > 0 && (cc1x[f] != cc1x[f-1] || cc1y[f] != cc1y[f-1] ||
                    cc2x[f] != cc2x[f-1] || cc2y[f] != cc2y[f-1])) incon = 1'b1;
      check({tag, "_rv"}, RES_VALID, 1);
      check({tag, "_cov"}, COVER_CNT, 32'(cov));
      check({tag, "_fail"}, FAIL, 32'(cov < ex));
      check({tag, "_res"}, {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y},
            {4'(cc1x[f]), 4'(cc1y[f]), 4'(cc2x[f]), 4'(cc2y[f])});
`ifdef LASER_HOST_CONSIST_EN
      check({tag, "_incon"}, INCONSIST, 32'(incon));
`endif
      @(negedge CLK);
      check({tag, "_busy_after"}, BUSY, 32'(f < nf - 1));
      check({tag, "_rv_after"}, RES_VALID, 0);
    end
    check({tag, "_rvcnt"}, 32'(rv_cnt - rv0), 32'(nf));
  endtask

  task automatic set_centres(input int f, input int a, input int b, input int c, input int d);
    cc1x[f] = a; cc1y[f] = b; cc2x[f] = c; cc2y[f] = d;
  endtask

  initial begin
    RST_N = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_X = '0; WR_Y = '0;
    START = 1'b0; FRAMES = '0; EXP_CNT = '0; DONE = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    repeat (2) @(negedge CLK);
    check_zero("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // All points on centre 1
    for (int i = 0; i < NP; i++) write_pt(i, 5, 5);
    set_centres(0, 5, 5, 9, 9);
    run_frames("basic", 1, 40, 3, 0, 0, 0, 0, 0, 0);

    // Radius boundary: (9,5) at d^2=16 counts, (10,5) at 25 does not
    write_pt(0, 9, 5);
    write_pt(1, 10, 5);
    for (int i = 2; i < NP; i++) write_pt(i, 15, 0);
    write_pt(63, 9, 5);
    set_centres(0, 5, 5, 0, 15);
    run_frames("bound", 1, 2, 0, 0, 0, 0, 0, 0, 0);

    // Three frames, long solver latency, identical centres
    for (int i = 0; i < NP; i++) write_pt(i, $urandom_range(0, 15), $urandom_range(0, 15));
    for (int f = 0; f < 3; f++) set_centres(f, 7, 3, 2, 12);
    run_frames("frames3", 3, 10, 500, 0, 1, 0, 0, 0, 0);

    // Solver never answers
    run_frames("hang", 2, 5, 0, 1, 0, 0, 0, 0, 0);

    // Centre drift between frames; DONE arrives on the timeout cycle itself
    set_centres(0, 4, 4, 11, 11);
    set_centres(1, 5, 4, 11, 11);
    run_frames("drift", 2, 0, TO - 1, 0, 0, 1, 0, 4, 4);

    // Reset mid-stream at idx 20
    START = 1'b1; FRAMES = 4'd1; EXP_CNT = 6'd0;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    repeat (20) @(negedge CLK);
    check("midrst_xy", {X, Y}, {px[20], py[20]});
    RST_N = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("midrst_idle_busy", BUSY, 0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      int fr;
      fr = $urandom_range(0, 3);
      for (int j = 0; j < 12; j++)
        write_pt($urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 15));
      for (int f = 0; f < 4; f++) begin
        if (f > 0 && $urandom_range(0, 1) == 1)
          set_centres(f, cc1x[f-1], cc1y[f-1], cc2x[f-1], cc2y[f-1]);
        else
          set_centres(f, $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15));
      end
      run_frames($sformatf("rnd%0d", r), fr, $urandom_range(0, 40), $urandom_range(0, 40),
                 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, NP - 1), $urandom_range(0, 15), $urandom_range(0, 15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
